decode_pipe_stage: RTL and testbench
====================================

Name: decode_pipe_stage

Overview:
- Next-generation RV32I/RV64I-width decode stage between ifetch and rfetch.
- Decodes every base-ISA format (R/I/S/B/U/J), flags illegal encodings and passes the PC through.
- Holds decoded bundles in a parametrised-depth output queue with valid/ready handshakes on both sides, plus a synchronous flush for branch redirect.

Parameters:
- XLEN, 32, datapath width of imm and pc; legal values 32 or 64.
- DEPTH, 2, number of decoded-bundle entries in the output queue; must be >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low; clears all state.
- flush_i  input  1  synchronous flush; empties the queue.
- in_v  input  1  instruction valid from ifetch.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  instruction PC.
- out_v  output  1  head bundle valid.
- out_ready  input  1  rfetch consumes the head this cycle.
- out_pc  output  XLEN  PC of the head bundle.
- out_opcode  output  7  instr[6:0].
- out_inst_type  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none.
- out_rs1, out_rs2, out_rd  output  5 each  register indices.
- out_rs1_v, out_rs2_v  output  1 each  source register is read.
- out_rd_w_v  output  1  destination is written.
- out_imm  output  XLEN  sign-extended immediate.
- out_imm_v  output  1  imm is an ALU operand.
- out_funct3  output  3  instr[14:12].
- out_alt_art  output  1  SUB/SRA select.
- out_illegal  output  1  illegal or unsupported encoding.

Behaviour:
- Reset (rst=0, asynchronous):
  - count, read pointer and write pointer go to 0; all queue entries go to 0.
  - All outputs read 0: out_v=0, in_ready=1, all payload outputs 0.
- Handshake:
  - in_ready = (count < DEPTH); it is independent of out_ready, so there is no pass-through when full.
  - Push when in_v && in_ready; pop when out_v && out_ready.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo DEPTH.
  - out_v = (count != 0). Payload outputs always show the head entry and are stable while out_v && !out_ready.
- Latency:
  - An instruction accepted in cycle N is visible at the head in N+1 when the queue was empty.
  - Decode is combinational on in_instr; the result is written into the queue.
- Flush (flush_i=1):
  - count and pointers go to 0 on the next edge; out_v=0 on the next cycle.
  - Any push in the same cycle is discarded. The pop handshake is ignored.
- Decode by opcode:
  - 0110111 LUI and 0010111 AUIPC: U type, rd_w_v=1.
  - 1101111 JAL: J type, rd_w_v=1.
  - 1100111 JALR: I type, rs1_v=1, rd_w_v=1. Illegal unless funct3=000.
  - 1100011 BRANCH: B type, rs1_v=1, rs2_v=1. funct3 010 and 011 are illegal.
  - 0000011 LOAD: I type, rs1_v=1, rd_w_v=1. funct3 011, 110 and 111 are illegal.
  - 0100011 STORE: S type, rs1_v=1, rs2_v=1. funct3 greater than 010 is illegal.
  - 0010011 OP-IMM: I type, rs1_v=1, rd_w_v=1, imm_v=1.
  - 0110011 OP: R type, rs1_v=1, rs2_v=1, rd_w_v=1.
  - 0001111 MISC-MEM and 1110011 SYSTEM: inst_type 7; treated as no-op, not illegal.
  - Any other opcode, or instr[1:0] != 11: illegal=1, inst_type=7.
- Illegal bundles are still queued in order, with rd_w_v, imm_v, rs1_v and rs2_v all 0.
- rd_w_v is forced to 0 when rd == 0.
- Immediates:
  - Sign bit is instr[31], extended to XLEN.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and none: imm = 0.
- Shift immediates (OP-IMM with funct3 001 or 101):
  - SW = log2(XLEN); imm = zero-extended instr[20+SW-1:20].
  - Illegal unless instr[31:20+SW] is all zero, apart from instr[30] for funct3 101.
  - funct3=001 with instr[30]=1 is illegal.
- alt_art:
  - OP-IMM with funct3=101: alt_art = instr[30].
  - OP with funct3 000 or 101: alt_art = instr[30].
  - Otherwise 0.
- OP funct7 rule: funct7 must be 0000000, or 0100000 only with funct3 000 or 101; anything else is illegal.
- Reset asserted mid-operation drops all queued bundles immediately.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) -> next cycle out_v=1, rd=1, imm=5, imm_v=1, rd_w_v=1, inst_type=1, illegal=0.
- Push 0x40208033 (sub x0,x1,x2) -> alt_art=1, rs1_v=1, rs2_v=1, rd_w_v=0 (rd=0), imm=0.
- Push 0xFE000EE3 (beq x0,x0,-4) -> inst_type=3, imm=0xFFFFFFFC. Push 0x000000EF (jal x1,0) -> inst_type=5, imm=0.
- With DEPTH=2 and out_ready=0, push 3 instructions -> in_ready=0 after the second accept, third is held; release out_ready -> bundles pop in order, no loss or duplication.
- Full queue, then flush_i=1 together with in_v=1 -> next cycle out_v=0, count=0, flushed-cycle instruction is absent.
- Push 0x0200D093 (srli with instr[25]=1, XLEN=32) -> illegal=1, rd_w_v=0. Push 0xFFFFFFFF -> illegal=1. Assert rst low mid-stream -> out_v=0 asynchronously.

Source files
------------

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: RV32I/RV64I decoder feeding a DEPTH-entry bundle queue with valid/ready handshakes and flush.
module decode_pipe_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_v,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_v,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_inst_type,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rs1_v,
  output logic            out_rs2_v,
  output logic            out_rd_w_v,
  output logic [XLEN-1:0] out_imm,
  output logic            out_imm_v,
  output logic [2:0]      out_funct3,
  output logic            out_alt_art,
  output logic            out_illegal
);
  localparam int SW = $clog2(XLEN);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      inst_type;
    logic [4:0]      rs1, rs2, rd;
    logic            rs1_v, rs2_v, rd_w_v;
    logic [XLEN-1:0] imm;
    logic            imm_v;
    logic [2:0]      funct3;
    logic            alt_art, illegal;
  } bundle_t;
  bundle_t q [DEPTH];
  bundle_t d;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push, pop, ill, r1, r2, rw, iv, alt, sh;
  logic [2:0] ty;
  logic signed [31:0] imm32, i_imm;
  logic [31:0] sh_hi;
  wire [6:0] op = in_instr[6:0];
  wire [2:0] f3 = in_instr[14:12];
  wire [6:0] f7 = in_instr[31:25];
  always_comb begin
    i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
    sh = f3[1:0] == 2'b01;
    sh_hi = in_instr & (32'hFFFF_FFFF << (20 + SW));
    sh_hi[30] = f3 == 3'b101 ? 1'b0 : sh_hi[30];
    ill = 1'b0; ty = 3'd7; r1 = 1'b0; r2 = 1'b0; rw = 1'b0; iv = 1'b0; alt = 1'b0; imm32 = '0;
    case (op)
      7'b0110111, 7'b0010111: begin ty = 3'd4; rw = 1'b1; imm32 = {in_instr[31:12], 12'b0}; end
      7'b1101111: begin
        ty = 3'd5; rw = 1'b1;
        imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b1100111: begin ty = 3'd1; r1 = 1'b1; rw = 1'b1; imm32 = i_imm; ill = f3 != 3'b000; end
      7'b1100011: begin
        ty = 3'd3; r1 = 1'b1; r2 = 1'b1; ill = f3[2:1] == 2'b01;
        imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0000011: begin
        ty = 3'd1; r1 = 1'b1; rw = 1'b1; imm32 = i_imm;
        ill = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      7'b0100011: begin
        ty = 3'd2; r1 = 1'b1; r2 = 1'b1; ill = f3 > 3'b010;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b0010011: begin
        ty = 3'd1; r1 = 1'b1; rw = 1'b1; iv = 1'b1;
        imm32 = sh ? 32'(in_instr[20 +: SW]) : i_imm;
        ill = sh && |sh_hi;
        alt = f3 == 3'b101 && in_instr[30];
      end
      7'b0110011: begin
        ty = 3'd0; r1 = 1'b1; r2 = 1'b1; rw = 1'b1;
        alt = (f3 == 3'b000 || f3 == 3'b101) && in_instr[30];
        ill = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      7'b0001111, 7'b1110011: ;
      default: ill = 1'b1;
    endcase
    d = '0;
    d.pc = in_pc;
    d.opcode = op;
    d.inst_type = ty;
    d.rs1 = in_instr[19:15];
    d.rs2 = in_instr[24:20];
    d.rd = in_instr[11:7];
    d.rs1_v = r1 && !ill;
    d.rs2_v = r2 && !ill;
    d.rd_w_v = rw && !ill && |in_instr[11:7];
    d.imm = XLEN'(imm32);
    d.imm_v = iv && !ill;
    d.funct3 = f3;
    d.alt_art = alt;
    d.illegal = ill;
  end
  assign in_ready = cnt < CW'(DEPTH);
  assign out_v = cnt != '0;
  assign push = in_v && in_ready;
  assign pop = out_v && out_ready;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush_i) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) q[wp] <= d;
      wp <= push ? nxt(wp) : wp;
      rp <= pop ? nxt(rp) : rp;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  assign out_pc = q[rp].pc;
  assign out_opcode = q[rp].opcode;
  assign out_inst_type = q[rp].inst_type;
  assign out_rs1 = q[rp].rs1;
  assign out_rs2 = q[rp].rs2;
  assign out_rd = q[rp].rd;
  assign out_rs1_v = q[rp].rs1_v;
  assign out_rs2_v = q[rp].rs2_v;
  assign out_rd_w_v = q[rp].rd_w_v;
  assign out_imm = q[rp].imm;
  assign out_imm_v = q[rp].imm_v;
  assign out_funct3 = q[rp].funct3;
  assign out_alt_art = q[rp].alt_art;
  assign out_illegal = q[rp].illegal;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb_decode_pipe_stage: directed vectors with hand-computed expectations for decode_pipe_stage.
module tb_decode_pipe_stage;
  logic clk = 1'b0, rst = 1'b0, flush_i = 1'b0, in_v = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_v, out_rs1_v, out_rs2_v, out_rd_w_v, out_imm_v, out_alt_art, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0] out_opcode;
  logic [2:0] out_inst_type, out_funct3;
  logic [4:0] out_rs1, out_rs2, out_rd;
  int n = 0, miss = 0;
  decode_pipe_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_v(in_v), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_v(out_v), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_inst_type(out_inst_type),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rs1_v(out_rs1_v),
    .out_rs2_v(out_rs2_v), .out_rd_w_v(out_rd_w_v), .out_imm(out_imm), .out_imm_v(out_imm_v),
    .out_funct3(out_funct3), .out_alt_art(out_alt_art), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n++;
    assert (o === e) else begin
      miss++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask
  task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
    in_v = 1'b1; in_instr = ins; in_pc = pc;
    step;
    in_v = 1'b0;
  endtask
  task automatic pop1;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask
  initial begin
    step; step;
    chk("rst_out_v", out_v, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_opcode", out_opcode, 0);
    rst = 1'b1;
    step;
    push1(32'h00500093, 32'h100);
    chk("addi_v", out_v, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_imm_v", out_imm_v, 1);
    chk("addi_rd_w_v", out_rd_w_v, 1);
    chk("addi_type", out_inst_type, 1);
    chk("addi_ill", out_illegal, 0);
    chk("addi_pc", out_pc, 32'h100);
    pop1;
    chk("addi_popped", out_v, 0);
    push1(32'h40208033, 32'h104);
    chk("sub_alt", out_alt_art, 1);
    chk("sub_rs1_v", out_rs1_v, 1);
    chk("sub_rs2_v", out_rs2_v, 1);
    chk("sub_rd_w_v", out_rd_w_v, 0);
    chk("sub_imm", out_imm, 0);
    chk("sub_type", out_inst_type, 0);
    pop1;
    push1(32'hFE000EE3, 32'h108);
    chk("beq_type", out_inst_type, 3);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_rd_w_v", out_rd_w_v, 0);
    pop1;
    push1(32'h000000EF, 32'h10C);
    chk("jal_type", out_inst_type, 5);
    chk("jal_imm", out_imm, 0);
    chk("jal_rd_w_v", out_rd_w_v, 1);
    pop1;
    push1(32'h00112223, 32'h110);
    chk("sw_type", out_inst_type, 2);
    chk("sw_imm", out_imm, 4);
    chk("sw_rd_w_v", out_rd_w_v, 0);
    pop1;
    push1(32'h123450B7, 32'h114);
    chk("lui_type", out_inst_type, 4);
    chk("lui_imm", out_imm, 32'h12345000);
    pop1;
    push1(32'h00500093, 32'h200);
    chk("fill_rdy1", in_ready, 1);
    push1(32'h00600113, 32'h204);
    chk("fill_rdy2", in_ready, 0);
    push1(32'h00700193, 32'h208);
    chk("full_hold_rdy", in_ready, 0);
    chk("full_hold_pc", out_pc, 32'h200);
    chk("full_hold_imm", out_imm, 5);
    in_v = 1'b1; in_instr = 32'h00700193; in_pc = 32'h208; out_ready = 1'b1;
    step;
    chk("drain_a_pc", out_pc, 32'h204);
    chk("drain_a_rdy", in_ready, 1);
    step;
    in_v = 1'b0;
    chk("drain_b_pc", out_pc, 32'h208);
    chk("drain_b_imm", out_imm, 7);
    chk("drain_b_v", out_v, 1);
    step;
    out_ready = 1'b0;
    chk("drain_c_v", out_v, 0);
    push1(32'h00500093, 32'h300);
    push1(32'h00500093, 32'h304);
    chk("flfull_rdy", in_ready, 0);
    flush_i = 1'b1; in_v = 1'b1; in_pc = 32'h308;
    step;
    flush_i = 1'b0; in_v = 1'b0;
    chk("flush_v", out_v, 0);
    chk("flush_rdy", in_ready, 1);
    push1(32'h00500093, 32'h500);
    flush_i = 1'b1; in_v = 1'b1; in_pc = 32'h504;
    step;
    flush_i = 1'b0; in_v = 1'b0;
    chk("flush_push_v", out_v, 0);
    push1(32'h00500093, 32'h400);
    chk("after_flush_pc", out_pc, 32'h400);
    pop1;
    chk("after_flush_empty", out_v, 0);
    push1(32'h0200D093, 32'h600);
    chk("srli_bad_ill", out_illegal, 1);
    chk("srli_bad_rd_w_v", out_rd_w_v, 0);
    chk("srli_bad_imm_v", out_imm_v, 0);
    pop1;
    push1(32'h4020D093, 32'h604);
    chk("srai_ill", out_illegal, 0);
    chk("srai_alt", out_alt_art, 1);
    chk("srai_imm", out_imm, 2);
    pop1;
    push1(32'hFFFFFFFF, 32'h608);
    chk("ones_ill", out_illegal, 1);
    chk("ones_type", out_inst_type, 7);
    chk("ones_rs1_v", out_rs1_v, 0);
    pop1;
    push1(32'h00500093, 32'h700);
    chk("pre_rst_v", out_v, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_v", out_v, 0);
    chk("async_rst_rdy", in_ready, 1);
    chk("async_rst_pc", out_pc, 0);
    step;
    rst = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n, miss);
    $finish;
  end
endmodule
